rst_seq_ctrl: RTL

Parametrised reset sequencer in the clk_c1 (100 MHz) domain. It holds every downstream reset asserted until the PLL lock is stable, then releases CH_NUM reset channels one at a time. Release order is channel 0 first, for example SDRAM controller, then camera capture, then LCD. The block re-runs the whole sequence on PLL lock loss or on a soft reset request. It replaces the fixed single-output 1000-cycle delay reset with lock qualification, staged release and lock-loss recovery.

---
 rtl/rst_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies PLL lock, then releases reset channels in
// ascending order; lock loss or soft reset restarts the whole sequence.
module rst_seq_ctrl #(
    parameter int CH_NUM      = 4,
    parameter int CNT_W       = 16,
    parameter int LOCK_FILTER = 16,
    parameter int INIT_DLY    = 1000,
    parameter int STEP_DLY    = 100
) (
    input  logic              clk_c1,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              soft_rst,
    output logic [CH_NUM-1:0] rst_n_o,
    output logic              all_done,
    output logic [1:0]        seq_state,
    output logic [7:0]        lock_lost_cnt
);

    localparam int SW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    localparam logic [CNT_W-1:0]  FILT_T = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]  INIT_T = CNT_W'(INIT_DLY - 1);
    localparam logic [CNT_W-1:0]  STEP_T = CNT_W'(STEP_DLY - 1);
    localparam logic [SW-1:0]     LAST   = SW'(CH_NUM - 1);
    localparam logic [CH_NUM-1:0] ONE    = CH_NUM'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        SEQ       = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [CH_NUM-1:0] rel_q, rel_d;
    logic              done_q, done_d;
    logic [7:0]        lost_q, lost_d;
    logic              sync1_q, lock_s_q;
    logic [CNT_W-1:0]  target;

    // pll_locked is asynchronous to clk_c1
    always_ff @(posedge clk_c1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_c1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            lost_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    assign target = (stage_q == '0) ? INIT_T : STEP_T;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rel_d   = rel_q;
        done_d  = done_q;
        lost_d  = lost_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d   = '0;
                stage_d = '0;
                rel_d   = '0;
                done_d  = 1'b0;
                if (lock_s_q) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (!lock_s_q || soft_rst) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == FILT_T) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEQ, DONE: begin
                if (!lock_s_q || soft_rst) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    stage_d = '0;
                    rel_d   = '0;
                    done_d  = 1'b0;
                    // only a genuine lock loss is counted
                    if (!lock_s_q && lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end else if (state_q == SEQ) begin
                    if (cnt_q == target) begin
                        rel_d = rel_q | (ONE << stage_q);
                        cnt_d = '0;
                        if (stage_q == LAST) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            stage_d = stage_q + SW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    assign rst_n_o       = rel_q;
    assign all_done      = done_q;
    assign seq_state     = state_q;
    assign lock_lost_cnt = lost_q;

endmodule
